avm_mem_responder: RTL and testbench
====================================

AVM_MEM_RESPONDER -- requirements
Module: avm_mem_responder

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32: data bus width in bits.
REQ-002 SHALL provide parameter ADDR_WIDTH, default 32: word address width.
REQ-003 SHALL provide parameter DEPTH_LOG2, default 8: log2 of storage depth in words.
REQ-004 SHALL provide parameter BASE_ADDR, default 32'h00000000: first word address served.
REQ-005 SHALL provide parameter WAIT_STATES, default 2, range 0..15: extra stall cycles per transfer.
REQ-006 SHALL provide port csi_clock_clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-007 SHALL provide port csi_clock_reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL provide port avs_avalonslave_address, input, ADDR_WIDTH bits: word address from master.
REQ-009 SHALL provide port avs_avalonslave_read, input, 1 bit: read request.
REQ-010 SHALL provide port avs_avalonslave_write, input, 1 bit: write request.
REQ-011 SHALL provide port avs_avalonslave_writedata, input, DATA_WIDTH bits: write data.
REQ-012 SHALL provide port avs_avalonslave_readdata, output, DATA_WIDTH bits: registered read data.
REQ-013 SHALL provide port avs_avalonslave_waitrequest, output, 1 bit: stall to master.
REQ-014 SHALL provide port err, output, 1 bit: sticky protocol/range error flag.

Function
REQ-015 SHALL implement FSM IDLE, WAIT, DONE; WAIT_STATES+2 cycles per transfer.
REQ-016 IDLE with read or write high: latch address, command and writedata; go to WAIT if WAIT_STATES>0, else DONE; waitrequest=1.
REQ-017 WAIT: stay exactly WAIT_STATES cycles (4-bit counter); waitrequest=1; address/data changes are ignored.
REQ-018 The readdata register SHALL load mem[index] on the cycle entering DONE.
REQ-019 DONE: waitrequest=0 for exactly one cycle; read data valid that cycle; write commits at the rising edge ending DONE; next state IDLE.
REQ-020 IDLE without request: waitrequest=0; readdata holds its last value.
REQ-021 Index = address - BASE_ADDR, modulo 2^ADDR_WIDTH; in range iff index < 2^DEPTH_LOG2.
REQ-022 Out-of-range read SHALL return 0; out-of-range write SHALL be dropped; both set err; timing unchanged.
REQ-023 read and write both high at latch: treat as write, set err.
REQ-024 Back-to-back requests: a request held high after DONE SHALL be relatched in the following IDLE cycle with no bubble beyond the IDLE cycle.

Reset
REQ-025 While csi_clock_reset_n=0: state=IDLE, counter=0, readdata=0, err=0, waitrequest=1.
REQ-026 Reset asserted mid-transfer SHALL abort it; a pending write SHALL NOT commit.
REQ-027 Reset SHALL NOT clear memory contents.

Configuration
REQ-028 Macro AVM_MEM_RESPONDER_BYTEENABLE_EN defined: add input avs_avalonslave_byteenable (DATA_WIDTH/8 bits), latched with the command; only enabled byte lanes are written in DONE; reads ignore it.
REQ-029 Macro not defined: no byteenable port; every write updates all byte lanes.

Verification
REQ-030 WAIT_STATES=2, write 0xDEADBEEF to 0x46 -> waitrequest high 3 cycles, low 1 cycle; mem[0x46]=0xDEADBEEF.
REQ-031 Read 0x46 after REQ-030 -> readdata=0xDEADBEEF in the waitrequest-low cycle; err=0.
REQ-032 BASE_ADDR=0, DEPTH_LOG2=8, read 0x100 -> readdata=0, err=1 until reset; write to 0x100 leaves memory unchanged.
REQ-033 Assert reset during WAIT of write 0x12345678 to 0x50 -> mem[0x50] unchanged; readdata=0; waitrequest=1 during reset.
REQ-034 read=write=1, address 0x64, writedata 0x5 -> mem[0x64]=0x5, err=1.
REQ-035 With AVM_MEM_RESPONDER_BYTEENABLE_EN, byteenable=4'b0011, write 0xAABBCCDD over 0x11111111 -> 0x1111CCDD.

Source files
------------

// File: rtl/avm_mem_responder.sv
// Avalon-MM slave backed by on-chip word storage, with a fixed number of wait states per transfer.
// Optional build macro AVM_MEM_RESPONDER_BYTEENABLE_EN adds per-byte write enables.
module avm_mem_responder #(
  parameter int          DATA_WIDTH  = 32,
  parameter int          ADDR_WIDTH  = 32,
  parameter int          DEPTH_LOG2  = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 2
) (
  input  logic                  csi_clock_clk,
  input  logic                  csi_clock_reset_n,
  input  logic [ADDR_WIDTH-1:0] avs_avalonslave_address,
  input  logic                  avs_avalonslave_read,
  input  logic                  avs_avalonslave_write,
  input  logic [DATA_WIDTH-1:0] avs_avalonslave_writedata,
`ifdef AVM_MEM_RESPONDER_BYTEENABLE_EN
  input  logic [DATA_WIDTH/8-1:0] avs_avalonslave_byteenable,
`endif
  output logic [DATA_WIDTH-1:0] avs_avalonslave_readdata,
  output logic                  avs_avalonslave_waitrequest,
  output logic                  err
);

  localparam int         LP_DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] LP_WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  state_t                  r_state, w_state_nxt;
  logic [3:0]              r_cnt;
  logic [DEPTH_LOG2-1:0]   r_idx;
  logic                    r_in_range;
  logic                    r_is_write;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH-1:0]   r_readdata;
  logic                    r_err;
  logic [DATA_WIDTH-1:0]   r_mem [LP_DEPTH];
`ifdef AVM_MEM_RESPONDER_BYTEENABLE_EN
  localparam int           LP_LANES = DATA_WIDTH / 8;
  logic [LP_LANES-1:0]     r_be;
`endif

  logic                    w_req;
  logic [ADDR_WIDTH-1:0]   w_in_off;
  logic                    w_in_range;
  logic [DEPTH_LOG2-1:0]   w_sel_idx;
  logic                    w_sel_in_range;
  logic                    w_waitrequest;

  // Offset wraps modulo 2^ADDR_WIDTH, so addresses below BASE_ADDR land far out of range.
  assign w_req      = avs_avalonslave_read | avs_avalonslave_write;
  assign w_in_off   = avs_avalonslave_address - ADDR_WIDTH'(BASE_ADDR);
  assign w_in_range = ({1'b0, w_in_off} < ((ADDR_WIDTH+1)'(1) << DEPTH_LOG2));

  // With zero wait states DONE is entered straight from IDLE, before the latch is visible.
  assign w_sel_idx      = (r_state == ST_IDLE) ? w_in_off[DEPTH_LOG2-1:0] : r_idx;
  assign w_sel_in_range = (r_state == ST_IDLE) ? w_in_range : r_in_range;

  always_ff @(posedge csi_clock_clk or negedge csi_clock_reset_n) begin
    if (!csi_clock_reset_n) r_state <= ST_IDLE;
    // NOTE: sequential state is always assigned with <= so every register samples pre-edge values.
    else                    r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_nxt   = r_state;
    w_waitrequest = 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        w_waitrequest = w_req;
        if (w_req) w_state_nxt = (LP_WS != 4'd0) ? ST_WAIT : ST_DONE;
      end
      ST_WAIT: if (r_cnt == LP_WS - 4'd1) w_state_nxt = ST_DONE;
      ST_DONE: begin
        w_waitrequest = 1'b0;
        w_state_nxt   = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (!csi_clock_reset_n) w_waitrequest = 1'b1;
  end

  always_ff @(posedge csi_clock_clk or negedge csi_clock_reset_n) begin
    if (!csi_clock_reset_n) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_in_range <= 1'b0;
      r_is_write <= 1'b0;
      r_wdata    <= '0;
      r_readdata <= '0;
      r_err      <= 1'b0;
`ifdef AVM_MEM_RESPONDER_BYTEENABLE_EN
      r_be       <= '0;
`endif
    end else begin
      r_cnt <= (r_state == ST_WAIT && w_state_nxt == ST_WAIT) ? r_cnt + 4'd1 : 4'd0;
      if (r_state == ST_IDLE && w_req) begin
        r_idx      <= w_in_off[DEPTH_LOG2-1:0];
        r_in_range <= w_in_range;
        r_is_write <= avs_avalonslave_write;
        r_wdata    <= avs_avalonslave_writedata;
`ifdef AVM_MEM_RESPONDER_BYTEENABLE_EN
        r_be       <= avs_avalonslave_byteenable;
`endif
        if (!w_in_range || (avs_avalonslave_read && avs_avalonslave_write)) r_err <= 1'b1;
      end
      if (w_state_nxt == ST_DONE)
        r_readdata <= w_sel_in_range ? r_mem[w_sel_idx] : '0;
    end
  end

  // NOTE: storage has no reset on purpose: contents survive reset and the array maps onto RAM.
  always_ff @(posedge csi_clock_clk) begin
    if (r_state == ST_DONE && r_is_write && r_in_range) begin
`ifdef AVM_MEM_RESPONDER_BYTEENABLE_EN
      for (int b = 0; b < LP_LANES; b++)
        if (r_be[b]) r_mem[r_idx][b*8 +: 8] <= r_wdata[b*8 +: 8];
`else
      r_mem[r_idx] <= r_wdata;
`endif
    end
  end

  assign avs_avalonslave_readdata    = r_readdata;
  assign avs_avalonslave_waitrequest = w_waitrequest;
  assign err                         = r_err;

endmodule

// File: tb/tb_avm_mem_responder.sv
// Self-checking bench for avm_mem_responder: directed vector table, multi-cycle corner
// sequences and randomized transfers scored against a simple word-array memory model.
module tb_avm_mem_responder;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int WS = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] address;
  logic          rd, wr;
  logic [DW-1:0] wdata, rdata;
  logic          waitreq, err_o;
`ifdef AVM_MEM_RESPONDER_BYTEENABLE_EN
  logic [DW/8-1:0] be;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  avm_mem_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH_LOG2(8), .BASE_ADDR(32'h0), .WAIT_STATES(WS)
  ) dut (
    .csi_clock_clk              (clk),
    .csi_clock_reset_n          (rst_n),
    .avs_avalonslave_address    (address),
    .avs_avalonslave_read       (rd),
    .avs_avalonslave_write      (wr),
    .avs_avalonslave_writedata  (wdata),
`ifdef AVM_MEM_RESPONDER_BYTEENABLE_EN
    .avs_avalonslave_byteenable (be),
`endif
    .avs_avalonslave_readdata   (rdata),
    .avs_avalonslave_waitrequest(waitreq),
    .err                        (err_o)
  );

  // Reference model: a 256-word array plus a sticky error bit.
  logic [31:0] m_mem [256];
  bit          m_err;

  typedef struct {
    bit          r;
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;
  vec_t tbl [12];

  function automatic logic [31:0] pat(input int i);
    return (32'(i) * 32'h0101_0101) ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Applies one transfer to the model; returns the data a plain read must see.
  task automatic model_apply(input bit r, input bit w, input logic [31:0] a,
                             input logic [31:0] d, output logic [31:0] exp_rd);
    bit in_range;
    in_range = (a < 32'd256);
    exp_rd   = in_range ? m_mem[a[7:0]] : 32'h0;
    if (w && in_range) m_mem[a[7:0]] = d;
    if (!in_range || (r && w)) m_err = 1'b1;
  endtask

  // Starts just after a rising edge; returns just after the edge that ends DONE.
  task automatic xfer(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] got_rd, output logic got_err, output int hi,
                      output bit done_ok);
    int c;
    address = a; rd = r; wr = w; wdata = d;
    hi = 0; done_ok = 1'b0; got_rd = '0; got_err = 1'b0; c = 0;
    while (!done_ok && c < 40) begin
      @(negedge clk);
      if (waitreq) hi++;
      else begin
        got_rd  = rdata;
        got_err = err_o;
        done_ok = 1'b1;
      end
      @(posedge clk); #1;
      c++;
    end
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic xfer_check(input string nm, input bit r, input bit w, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] exp_rd, input bit exp_err);
    logic [31:0] got_rd;
    logic        got_err;
    int          hi;
    bit          ok;
    xfer(r, w, a, d, got_rd, got_err, hi, ok);
    check({nm, " completes"}, 32'(ok), 32'd1);
    check({nm, " waitrequest-high cycles"}, 32'(hi), 32'(WS + 1));
    if (r && !w) check({nm, " readdata"}, got_rd, exp_rd);
    check({nm, " err"}, 32'(got_err), 32'(exp_err));
  endtask

  task automatic run_vec(input string nm, input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] d);
    logic [31:0] exp_rd;
    model_apply(r, w, a, d, exp_rd);
    xfer_check(nm, r, w, a, d, exp_rd, m_err);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] dummy;
    bit          exp_wait [8];
    rd = 1'b0; wr = 1'b0; address = '0; wdata = '0; m_err = 1'b0;
`ifdef AVM_MEM_RESPONDER_BYTEENABLE_EN
    be = '1;
`endif

    tbl[0]  = '{1'b0, 1'b1, 32'h46,       32'hDEAD_BEEF, 32'h0,         1'b0};
    tbl[1]  = '{1'b1, 1'b0, 32'h46,       32'h0,         32'hDEAD_BEEF, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 32'h10,       32'h0000_00A5, 32'h0,         1'b0};
    tbl[3]  = '{1'b1, 1'b0, 32'h10,       32'h0,         32'h0000_00A5, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 32'h00,       32'h0,         pat(0),        1'b0};
    tbl[5]  = '{1'b1, 1'b0, 32'h100,      32'h0,         32'h0,         1'b1};
    tbl[6]  = '{1'b0, 1'b1, 32'h100,      32'hCAFE_F00D, 32'h0,         1'b1};
    tbl[7]  = '{1'b1, 1'b0, 32'hFF,       32'h0,         pat(255),      1'b1};
    tbl[8]  = '{1'b1, 1'b1, 32'h64,       32'h0000_0005, 32'h0,         1'b1};
    tbl[9]  = '{1'b1, 1'b0, 32'h64,       32'h0,         32'h0000_0005, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0,        32'h0,         1'b1};
    tbl[11] = '{1'b1, 1'b0, 32'h00,       32'h0,         pat(0),        1'b1};

    // Reset state, with no request pending.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset waitrequest", 32'(waitreq), 32'd1);
    check("reset readdata", rdata, 32'h0);
    check("reset err", 32'(err_o), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("idle waitrequest", 32'(waitreq), 32'd0);
    @(posedge clk); #1;

    // Fill every word with a known pattern through the write path.
    for (int i = 0; i < 256; i++) run_vec($sformatf("init[%0d]", i), 1'b0, 1'b1, 32'(i), pat(i));

    // Directed vector table.
    for (int i = 0; i < 12; i++) begin
      model_apply(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, dummy);
      xfer_check($sformatf("vec[%0d]", i), tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d,
                 tbl[i].exp_rd, tbl[i].exp_err);
    end

    // Reset during the WAIT phase of a write aborts it and clears the flags.
    address = 32'h50; wdata = 32'h1234_5678; wr = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort in WAIT waitrequest", 32'(waitreq), 32'd1);
    rst_n = 1'b0; wr = 1'b0;
    #1;
    check("abort reset waitrequest", 32'(waitreq), 32'd1);
    check("abort reset readdata", rdata, 32'h0);
    check("abort reset err", 32'(err_o), 32'd0);
    m_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec("read after aborted write", 1'b1, 1'b0, 32'h50, 32'h0);

    // Back-to-back reads with request held high; address changes in WAIT are ignored.
    exp_wait = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    address = 32'h46; rd = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("b2b waitrequest[%0d]", k), 32'(waitreq), 32'(exp_wait[k]));
      if (k == 3) check("b2b first readdata", rdata, m_mem[8'h46]);
      if (k == 7) check("b2b second readdata", rdata, m_mem[8'h10]);
      @(posedge clk); #1;
      if (k == 3) address = 32'h10;
      if (k == 5) address = 32'h46;
    end
    rd = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("idle hold readdata[%0d]", k), rdata, m_mem[8'h10]);
      check($sformatf("idle hold waitrequest[%0d]", k), 32'(waitreq), 32'd0);
      @(posedge clk); #1;
    end

`ifdef AVM_MEM_RESPONDER_BYTEENABLE_EN
    be = 4'hF;
    run_vec("be full write", 1'b0, 1'b1, 32'h20, 32'h1111_1111);
    be = 4'b0011;
    xfer_check("be partial write", 1'b0, 1'b1, 32'h20, 32'hAABB_CCDD, 32'h0, m_err);
    m_mem[8'h20] = 32'h1111_CCDD;
    be = 4'b0000;
    run_vec("be read ignores byteenable", 1'b1, 1'b0, 32'h20, 32'h0);
    be = 4'hF;
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 300; n++) begin
      bit          r, w;
      logic [31:0] a;
      int          sel;
      sel = int'($urandom_range(0, 15));
      r = (sel < 7) || (sel == 15);
      w = (sel >= 7);
      a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 255));
      run_vec($sformatf("rand[%0d]", n), r, w, a, $urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
